// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Brief    : Shared constants for the scoreboarded register file.
// Revision : 1.0  initial release
// ============================================================================
package reg_file_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    // Architectural zero register: reads zero, never written, never busy.
    localparam int REG_ZERO       = 0;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_busy_table.sv
`default_nettype none
// ============================================================================
// Module   : reg_busy_table
// Brief    : Per-register busy scoreboard with a running count of busy entries.
//            Issue sets a bit, write-back clears it; issue wins on a collision.
// Revision : 1.0  initial release
// ============================================================================
module reg_busy_table
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    output logic [(1<<ADDR_W)-1:0]  busy,
    output logic [ADDR_W:0]         pending_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [ADDR_W:0]  r_cnt;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_iss_valid;
    logic             w_wr_valid;
    logic             w_same_addr;
    logic             w_set;
    logic             w_clr;

    assign w_iss_valid = iss_en && (iss_addr != ADDR_W'(REG_ZERO));
    assign w_wr_valid  = wr_en  && (wr_addr  != ADDR_W'(REG_ZERO));
    assign w_same_addr = w_iss_valid && w_wr_valid && (iss_addr == wr_addr);

    // Count moves only on real 0->1 / 1->0 transitions so it tracks popcount.
    assign w_set = w_iss_valid && !r_busy[iss_addr];
    assign w_clr = w_wr_valid && r_busy[wr_addr] && !w_same_addr;

    // Next busy vector: clear for write-back first, then set for issue.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_valid) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_iss_valid) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
    end

    // Busy bits and pending count, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= r_cnt + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_clr};
        end
    end

    assign busy        = r_busy;
    assign pending_cnt = r_cnt;

endmodule : reg_busy_table
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : Multi-read-port register file with one write-back port and a
//            busy scoreboard. Register 0 reads zero and is never busy.
//            Optional macro REGFILE_BYPASS_EN: write-through from the
//            write-back port to matching read ports in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [ADDR_W:0]            pending_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_wr_valid;

    assign w_wr_valid = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    reg_busy_table #(
        .ADDR_W      (ADDR_W)
    ) u_busy (
        .clk         (clk),
        .rst         (rst),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (w_busy),
        .pending_cnt (pending_cnt)
    );

    // Data array: write-back stores, register 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // A re-issue of the register being written keeps it busy for its new producer.
    logic w_reissue;
    assign w_reissue = iss_en && (iss_addr == wr_addr);
`endif

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_rbusy;

        assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

        // Read mux from stored state, optional write-through, zero register forced.
        always_comb begin
            w_data  = r_regs[w_addr];
            w_rbusy = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_valid && (w_addr == wr_addr)) begin
                w_data  = wr_data;
                w_rbusy = w_reissue;
            end
`endif
            if (w_addr == ADDR_W'(REG_ZERO)) begin
                w_data  = '0;
                w_rbusy = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = w_data;
        assign rd_busy[i]                  = w_rbusy;
    end

endmodule : reg_file_sb
`default_nettype wire
